// File: rtl/fc_mac_engine_if.sv
// rtl/fc_mac_engine_if.sv - weight ROM, activation buffer and result stream bundle for fc_mac_engine
interface fc_mac_engine_if #(
    parameter int W_ADDR = 9,
    parameter int W_ACT  = 5,
    parameter int DATA_W = 16
);
    logic [W_ADDR-1:0] weight_addr_a;
    logic [W_ADDR-1:0] weight_addr_b;
    logic [DATA_W-1:0] weight_q_a;
    logic [DATA_W-1:0] weight_q_b;
    logic [W_ACT-1:0]  act_addr_a;
    logic [W_ACT-1:0]  act_addr_b;
    logic [DATA_W-1:0] act_q_a;
    logic [DATA_W-1:0] act_q_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [W_ADDR-1:0] out_idx;

    modport master (
        output weight_addr_a, weight_addr_b, act_addr_a, act_addr_b,
        input  weight_q_a, weight_q_b, act_q_a, act_q_b,
        output out_valid, out_data, out_idx,
        input  out_ready
    );

    modport slave (
        input  weight_addr_a, weight_addr_b, act_addr_a, act_addr_b,
        output weight_q_a, weight_q_b, act_q_a, act_q_b,
        input  out_valid, out_data, out_idx,
        output out_ready
    );
endinterface

// File: rtl/fc_mac_engine.sv
// rtl/fc_mac_engine.sv - fully-connected layer MAC engine, 2 MACs/cycle; FC_RELU_EN adds ReLU on results
module fc_mac_engine #(
    parameter int N_IN   = 32,
    parameter int N_OUT  = 16,
    parameter int W_ADDR = 9,
    parameter int W_ACT  = 5,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    fc_mac_engine_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [W_ACT-1:0]  I_LAST = W_ACT'(N_IN / 2 - 1);
    localparam logic [W_ADDR-1:0] N_LAST = W_ADDR'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state, state_next;

    logic [W_ACT-1:0]  i_cnt;
    logic [W_ADDR-1:0] n_cnt;
    logic              drain_cnt;
    logic              q_vld;
    logic              p_vld;
    logic              accept;
    logic              clear_acc;

    logic signed [PROD_W-1:0] mul_a, mul_b;
    logic signed [PROD_W-1:0] p_a, p_b;
    logic signed [ACC_W-1:0]  acc, acc_next, r;
    logic [DATA_W-1:0]        result;

    logic [W_ADDR-1:0] wa, wb;
    logic [W_ACT-1:0]  aa, ab;
    logic [DATA_W-1:0] od;
    logic [W_ADDR-1:0] oi;

    assign bus.weight_addr_a = wa;
    assign bus.weight_addr_b = wb;
    assign bus.act_addr_a    = aa;
    assign bus.act_addr_b    = ab;
    assign bus.out_data      = od;
    assign bus.out_idx       = oi;

    assign accept    = (state == S_OUT) && bus.out_ready;
    assign clear_acc = ((state == S_IDLE) && start) || accept;

    assign mul_a = $signed(bus.weight_q_a) * $signed(bus.act_q_a);
    assign mul_b = $signed(bus.weight_q_b) * $signed(bus.act_q_b);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b1;
        done          = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_cnt == I_LAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt) state_next = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = (n_cnt == N_LAST) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Neuron boundaries clear the sum; the pipeline is always empty at those points.
    always_comb begin
        acc_next = acc;
        if (clear_acc) begin
            acc_next = '0;
        end else if (p_vld) begin
            acc_next = acc + {{(ACC_W-PROD_W){p_a[PROD_W-1]}}, p_a}
                           + {{(ACC_W-PROD_W){p_b[PROD_W-1]}}, p_b};
        end
    end

    // Result is taken from acc_next so the final pair lands in the same edge that enters OUT.
    always_comb begin
        r = acc_next >>> FRAC;
        if (r > SAT_MAX) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (r < SAT_MIN) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = r[DATA_W-1:0];
        end
`ifdef FC_RELU_EN
        if (result[DATA_W-1]) result = '0;
`else
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            i_cnt     <= '0;
            n_cnt     <= '0;
            drain_cnt <= 1'b0;
            q_vld     <= 1'b0;
            p_vld     <= 1'b0;
            p_a       <= '0;
            p_b       <= '0;
            acc       <= '0;
            wa        <= '0;
            wb        <= '0;
            aa        <= '0;
            ab        <= '0;
            od        <= '0;
            oi        <= '0;
        end else begin
            q_vld <= (state == S_ISSUE);
            p_vld <= q_vld;
            acc   <= acc_next;
            if (q_vld) begin
                p_a <= mul_a;
                p_b <= mul_b;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_cnt     <= '0;
                        n_cnt     <= '0;
                        drain_cnt <= 1'b0;
                        wa        <= '0;
                        wb        <= W_ADDR'(1);
                        aa        <= '0;
                        ab        <= W_ACT'(1);
                    end
                end
                S_ISSUE: begin
                    drain_cnt <= 1'b0;
                    if (i_cnt != I_LAST) begin
                        i_cnt <= i_cnt + 1'b1;
                        wa    <= wa + W_ADDR'(2);
                        wb    <= wb + W_ADDR'(2);
                        aa    <= aa + W_ACT'(2);
                        ab    <= ab + W_ACT'(2);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        od <= result;
                        oi <= n_cnt;
                    end
                end
                S_OUT: begin
                    // Weight rows are contiguous, so the next neuron base is last address + 2.
                    if (bus.out_ready && (n_cnt != N_LAST)) begin
                        n_cnt <= n_cnt + 1'b1;
                        i_cnt <= '0;
                        wa    <= wa + W_ADDR'(2);
                        wb    <= wb + W_ADDR'(2);
                        aa    <= '0;
                        ab    <= W_ACT'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_mac_engine.sv
// tb/tb_fc_mac_engine.sv - directed self-checking bench for fc_mac_engine
module tb_fc_mac_engine;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rom  [512];
    logic [15:0] abuf [32];

    logic [15:0] res_data [16];
    logic [8:0]  res_idx  [16];
    int beats;
    int done_cyc;
    bit timed_out;

    fc_mac_engine_if #(.W_ADDR(9), .W_ACT(5), .DATA_W(16)) bus ();

    fc_mac_engine dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.weight_q_a <= rom[bus.weight_addr_a];
        bus.weight_q_b <= rom[bus.weight_addr_b];
        bus.act_q_a    <= abuf[bus.act_addr_a];
        bus.act_q_b    <= abuf[bus.act_addr_b];
    end

    task automatic fill(input logic [15:0] w, input logic [15:0] a, input bit ramp);
        for (int k = 0; k < 512; k++) rom[k] = ramp ? 16'(k) : w;
        for (int k = 0; k < 32; k++) abuf[k] = a;
    endtask

    task automatic run_layer();
        int cyc;
        beats = 0;
        done_cyc = -1;
        timed_out = 0;
        for (int k = 0; k < 16; k++) begin
            res_data[k] = 'x;
            res_idx[k]  = 'x;
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 2000) begin
            if (bus.out_valid && bus.out_ready) begin
                if (beats < 16) begin
                    res_data[beats] = bus.out_data;
                    res_idx[beats]  = bus.out_idx;
                end
                beats++;
            end
            if (done) done_cyc = cyc;
            @(negedge clock);
            cyc++;
        end
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, done, bus.out_valid} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {busy, done, bus.out_valid});
        vectors++;
        if ({bus.out_data, bus.out_idx} !== 25'h0)
            $display("FAIL reset_out: got %h/%h want 0/0", bus.out_data, bus.out_idx);
        vectors++;
        if ({bus.weight_addr_a, bus.weight_addr_b, bus.act_addr_a, bus.act_addr_b} !== 28'h0)
            $display("FAIL reset_addr: got %h %h %h %h want 0", bus.weight_addr_a, bus.weight_addr_b,
                     bus.act_addr_a, bus.act_addr_b);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_uniform();
        fill(16'h0100, 16'h0100, 0);
        bus.out_ready = 1'b1;
        run_layer();
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL uniform_timeout: got no done want done"); end
        vectors++;
        if (beats !== 16) begin miscompares++; $display("FAIL uniform_beats: got %0d want 16", beats); end
        vectors++;
        if (done_cyc !== 305) begin miscompares++; $display("FAIL uniform_done_cycle: got %0d want 305", done_cyc); end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_idx[k] !== 9'(k)) begin
                miscompares++;
                $display("FAIL uniform_idx[%0d]: got %h want %h", k, res_idx[k], 9'(k));
            end
            vectors++;
            if (res_data[k] !== 16'h2000) begin
                miscompares++;
                $display("FAIL uniform_data[%0d]: got %h want 2000", k, res_data[k]);
            end
        end
    endtask

    task automatic test_saturation();
        fill(16'h7FFF, 16'h7FFF, 0);
        bus.out_ready = 1'b1;
        run_layer();
        vectors++;
        if (beats !== 16 || timed_out) begin
            miscompares++;
            $display("FAIL sat_beats: got %0d want 16", beats);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== 16'h7FFF) begin
                miscompares++;
                $display("FAIL sat_data[%0d]: got %h want 7fff", k, res_data[k]);
            end
        end
    endtask

    task automatic test_negative();
        logic [15:0] want;
`ifdef FC_RELU_EN
        want = 16'h0000;
`else
        want = 16'hE000;
`endif
        fill(16'hFF00, 16'h0100, 0);
        bus.out_ready = 1'b1;
        run_layer();
        vectors++;
        if (beats !== 16 || timed_out) begin
            miscompares++;
            $display("FAIL neg_beats: got %0d want 16", beats);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (res_data[k] !== want) begin
                miscompares++;
                $display("FAIL neg_data[%0d]: got %h want %h", k, res_data[k], want);
            end
        end
    endtask

    task automatic test_ramp(input logic [15:0] act, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e15);
        fill(16'h0000, act, 1);
        bus.out_ready = 1'b1;
        run_layer();
        vectors++;
        if (beats !== 16 || timed_out) begin
            miscompares++;
            $display("FAIL ramp_beats: got %0d want 16", beats);
        end
        vectors++;
        if (res_data[0] !== e0) begin
            miscompares++;
            $display("FAIL ramp_n0 act=%h: got %h want %h", act, res_data[0], e0);
        end
        vectors++;
        if (res_data[1] !== e1) begin
            miscompares++;
            $display("FAIL ramp_n1 act=%h: got %h want %h", act, res_data[1], e1);
        end
        vectors++;
        if (res_data[15] !== e15 || res_idx[15] !== 9'd15) begin
            miscompares++;
            $display("FAIL ramp_n15 act=%h: got %h idx %0d want %h idx 15", act, res_data[15], res_idx[15], e15);
        end
    endtask

    task automatic test_backpressure();
        int n;
        fill(16'h0100, 16'h0100, 0);
        bus.out_ready = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clock); n++; end
        vectors++;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_timeout: got no out_valid want 1"); end
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 16'h2000, 9'd0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h i=%0d want v=1 d=2000 i=0", c, bus.out_valid,
                         bus.out_data, bus.out_idx);
            end
            vectors++;
            if ({bus.weight_addr_a, bus.weight_addr_b, bus.act_addr_a, bus.act_addr_b} !==
                {9'd30, 9'd31, 5'd30, 5'd31}) begin
                miscompares++;
                $display("FAIL bp_addr[%0d]: got %0d %0d %0d %0d want 30 31 30 31", c, bus.weight_addr_a,
                         bus.weight_addr_b, bus.act_addr_a, bus.act_addr_b);
            end
            if (c < 5) @(negedge clock);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus.out_valid, bus.weight_addr_a} !== {1'b0, 9'd32}) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b wa=%0d want v=0 wa=32", bus.out_valid, bus.weight_addr_a);
        end
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clock); n++; end
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 16'h2000, 9'd1}) begin
            miscompares++;
            $display("FAIL bp_next: got v=%b d=%h i=%0d want v=1 d=2000 i=1", bus.out_valid, bus.out_data,
                     bus.out_idx);
        end
        n = 0;
        while (!done && n < 1000) begin @(negedge clock); n++; end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done: got %b want 1", done); end
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        bit bad;
        fill(16'h0100, 16'h0100, 0);
        bus.out_ready = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        seen = 0;
        while (seen < 3 && n < 200) begin
            if (bus.out_valid && bus.out_ready) seen++;
            @(negedge clock);
            n++;
        end
        vectors++;
        if ({busy, bus.weight_addr_a} !== {1'b1, 9'd96}) begin
            miscompares++;
            $display("FAIL abort_n3_issue: got busy=%b wa=%0d want busy=1 wa=96", busy, bus.weight_addr_a);
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if ({busy, bus.weight_addr_a} !== {1'b1, 9'd100}) begin
            miscompares++;
            $display("FAIL abort_start_ignored: got busy=%b wa=%0d want busy=1 wa=100", busy, bus.weight_addr_a);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        vectors++;
        if ({busy, done, bus.out_valid, bus.out_data, bus.out_idx} !== 28'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b v=%b d=%h i=%0d want all 0", busy, done,
                     bus.out_valid, bus.out_data, bus.out_idx);
        end
        vectors++;
        if ({bus.weight_addr_a, bus.weight_addr_b, bus.act_addr_a, bus.act_addr_b} !== 28'h0) begin
            miscompares++;
            $display("FAIL abort_addr: got %0d %0d %0d %0d want 0", bus.weight_addr_a, bus.weight_addr_b,
                     bus.act_addr_a, bus.act_addr_b);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) bad = 1;
            @(negedge clock);
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL abort_quiet: got done/busy after reset want none"); end
        run_layer();
        vectors++;
        if (beats !== 16 || timed_out || res_idx[0] !== 9'd0 || res_data[0] !== 16'h2000) begin
            miscompares++;
            $display("FAIL abort_rerun: got beats=%0d idx0=%0d d0=%h want 16 0 2000", beats, res_idx[0],
                     res_data[0]);
        end
        vectors++;
        if (done_cyc !== 305) begin miscompares++; $display("FAIL abort_rerun_done: got %0d want 305", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_saturation();
        test_negative();
        test_ramp(16'h0100, 16'h01F0, 16'h05F0, 16'h3DF0);
        test_ramp(16'h0001, 16'h0001, 16'h0005, 16'h003D);
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
